// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU datapath: operand layout, format constants
// and operand classification helpers.
package fpu_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam int unsigned EXP_BIAS     = 127;
   localparam logic [7:0]  EXP_MAX      = 8'hFF;
   localparam logic [31:0] QNAN_DEFAULT = 32'hFFC0_0000;
   localparam logic [31:0] POS_INF      = 32'h7F80_0000;

   function automatic logic is_nan(fp32_t v);
      return (v.exp == EXP_MAX) && (v.frac != 23'd0);
   endfunction

   function automatic logic is_inf(fp32_t v);
      return (v.exp == EXP_MAX) && (v.frac == 23'd0);
   endfunction

   function automatic logic is_zero(fp32_t v);
      return (v.exp == 8'd0) && (v.frac == 23'd0);
   endfunction

endpackage

// File: rtl/fdiv_lzc.sv
// Leading-zero counter over a 23-bit fraction; an all-zero input reports 23.
module fdiv_lzc (
   input  logic [22:0] frac_i,
   output logic [4:0]  cnt_o
);

   // Ascending scan so the highest set bit is the last one to write the count.
   always_comb begin
      cnt_o = 5'd23;
      for (int i = 0; i < 23; i++) begin
         if (frac_i[i]) cnt_o = 5'(22 - i);
      end
   end

endmodule

// File: rtl/fdiv_unit.sv
// IEEE-754 binary32 divider y = x1 / x2: RNE rounding, full subnormal support, one-cycle
// registered output. Define FDIV_DEBUG_EN to drive the mm/s2a debug taps; otherwise they read 0.
module fdiv_unit
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        out_valid,
   output logic [31:0] y,
   output logic        ovf,
   output logic [66:0] mm,
   output logic [4:0]  s2a
);

   fp32_t a, b;
   assign a = x1;
   assign b = x2;

   logic [4:0] lzc1, lzc2;

   fdiv_lzc u_lzc1 (
      .frac_i (a.frac),
      .cnt_o  (lzc1)
   );

   fdiv_lzc u_lzc2 (
      .frac_i (b.frac),
      .cnt_o  (lzc2)
   );

   logic [22:0]        f1n, f2n;
   logic [23:0]        m1, m2;
   logic signed [11:0] e1, e2, e_n, e_f, sh_raw;
   logic [66:0]        num, den, q, rem;
   logic               q_ge1, uf, g, stk, rnd, sgn;
   logic [43:0]        qn;
   logic [6:0]         sh;
   logic [127:0]       shv;
   logic [23:0]        mant;
   logic [24:0]        mr;
   logic [31:0]        fin, y_c;
   logic               ovf_c;

   // Unpack: subnormals are normalised so both significands carry a leading one at bit 23.
   always_comb begin
      f1n = a.frac << lzc1;
      f2n = b.frac << lzc2;
      if (a.exp != 8'd0) begin
         m1 = {1'b1, a.frac};
         e1 = $signed({4'd0, a.exp});
      end else begin
         m1 = {f1n, 1'b0};
         e1 = -$signed({7'd0, lzc1});
      end
      if (b.exp != 8'd0) begin
         m2 = {1'b1, b.frac};
         e2 = $signed({4'd0, b.exp});
      end else begin
         m2 = {f2n, 1'b0};
         e2 = -$signed({7'd0, lzc2});
      end
   end

   // Divide, normalise, denormalise on underflow, then round to nearest even.
   always_comb begin
      num    = {m1, 43'd0};
      den    = {43'd0, (m2 == 24'd0) ? 24'd1 : m2};
      q      = num / den;
      rem    = num % den;
      q_ge1  = |q[66:43];
      qn     = q_ge1 ? q[43:0] : {q[42:0], 1'b0};
      e_n    = e1 - e2 + $signed(12'(EXP_BIAS)) - (q_ge1 ? 12'sd0 : 12'sd1);
      uf     = (e_n < 12'sd1);
      sh_raw = 12'sd1 - e_n;
      if (!uf) begin
         sh = 7'd0;
      end else if (sh_raw > 12'sd64) begin
         sh = 7'd64;
      end else begin
         sh = sh_raw[6:0];
      end
      shv  = {qn, 84'd0} >> sh;
      mant = shv[127:104];
      g    = shv[103];
      stk  = (|shv[102:0]) | (|rem);
      rnd  = g & (stk | mant[0]);
      mr   = {1'b0, mant} + {24'd0, rnd};
      e_f  = e_n + (mr[24] ? 12'sd1 : 12'sd0);
      sgn  = a.sign ^ b.sign;
      if (uf) begin
         // A rounding carry into bit 23 lands in the exponent field as the minimum normal.
         fin = {sgn, 7'd0, mr[23], mr[22:0]};
      end else if (e_f > 12'sd254) begin
         fin = {sgn, POS_INF[30:0]};
      end else begin
         fin = {sgn, e_f[7:0], mr[22:0]};
      end
   end

   always_comb begin
      y_c = fin;
      if (is_nan(a)) begin
         y_c = x1 | 32'h0040_0000;
      end else if (is_nan(b)) begin
         y_c = x2 | 32'h0040_0000;
      end else if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) begin
         y_c = QNAN_DEFAULT;
      end else if (is_inf(a)) begin
         y_c = {sgn, POS_INF[30:0]};
      end else if (is_inf(b)) begin
         y_c = {sgn, 31'd0};
      end else if (is_zero(b)) begin
         y_c = {sgn, POS_INF[30:0]};
      end else if (is_zero(a)) begin
         y_c = {sgn, 31'd0};
      end
      ovf_c = (a.exp != EXP_MAX) && (b.exp != EXP_MAX) && (y_c[30:23] == EXP_MAX);
   end

   logic        out_valid_d, out_valid_q;
   logic [31:0] y_d, y_q;
   logic        ovf_d, ovf_q;
   logic [66:0] mm_d, mm_q;
   logic [4:0]  s2a_d, s2a_q;

   always_comb begin
      out_valid_d = in_valid;
      y_d         = y_q;
      ovf_d       = ovf_q;
      mm_d        = mm_q;
      s2a_d       = s2a_q;
      if (in_valid) begin
         y_d   = y_c;
         ovf_d = ovf_c;
`ifdef FDIV_DEBUG_EN
         mm_d  = q;
         s2a_d = ((b.exp == 8'd0) && (b.frac != 23'd0)) ? lzc2 : 5'd0;
`else
         mm_d  = 67'd0;
         s2a_d = 5'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= 32'd0;
         ovf_q       <= 1'b0;
         mm_q        <= 67'd0;
         s2a_q       <= 5'd0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         ovf_q       <= ovf_d;
         mm_q        <= mm_d;
         s2a_q       <= s2a_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign ovf       = ovf_q;
   assign mm        = mm_q;
   assign s2a       = s2a_q;

endmodule

// File: tb/tb_fdiv_unit.sv
// Self-checking bench for fdiv_unit: vector table streamed back-to-back through a scoreboard,
// plus reset, hold and reset-drop sequences.
module tb_fdiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] x1, x2;
   logic        out_valid;
   logic [31:0] y;
   logic        ovf;
   logic [66:0] mm;
   logic [4:0]  s2a;

   fdiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x1        (x1),
      .x2        (x2),
      .out_valid (out_valid),
      .y         (y),
      .ovf       (ovf),
      .mm        (mm),
      .s2a       (s2a)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      logic [4:0]  s2a;
      int          idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [66:0] act, input logic [66:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [4:0] exp_s2a(input logic [31:0] v);
      logic [4:0] n;
      n = 5'd0;
      if (v[30:23] == 8'd0) begin
         for (int i = 0; i < 23; i++) begin
            if (v[i]) n = 5'(22 - i);
         end
      end
`ifdef FDIV_DEBUG_EN
      return n;
`else
      return (n == 5'd31) ? 5'd1 : 5'd0;
`endif
   endfunction

   task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] yv,
                      input logic o);
      vec_t v;
      v.a = a; v.b = b; v.y = yv; v.ovf = o;
      vecs.push_back(v);
   endtask

   task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] yv, input logic o);
      exp_t e;
      x1 = a; x2 = b; in_valid = 1'b1;
      e.y = yv; e.ovf = o; e.s2a = exp_s2a(b); e.idx = idx;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (out_valid) begin
         if (sb.size() == 0) begin
            chk("spurious out_valid", {66'd0, out_valid}, 67'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("y[%0d]", e.idx), {35'd0, y}, {35'd0, e.y});
            chk($sformatf("ovf[%0d]", e.idx), {66'd0, ovf}, {66'd0, e.ovf});
            chk($sformatf("s2a[%0d]", e.idx), {62'd0, s2a}, {62'd0, e.s2a});
`ifndef FDIV_DEBUG_EN
            chk($sformatf("mm[%0d]", e.idx), mm, 67'd0);
`endif
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      add(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
      add(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      add(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
      add(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
      add(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1);
      add(32'h00000000, 32'h00000000, 32'hFFC00000, 1'b1);
      add(32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0);
      add(32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b0);
      add(32'h00800000, 32'h40000000, 32'h00400000, 1'b0);
      add(32'h00000001, 32'h40000000, 32'h00000000, 1'b0);
      add(32'h00000003, 32'h40000000, 32'h00000002, 1'b0);
      add(32'h00000001, 32'h00000001, 32'h3F800000, 1'b0);
      add(32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b0);
      add(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0);
      add(32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0);
      add(32'h80000000, 32'h40A00000, 32'h80000000, 1'b0);
      add(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0);
      add(32'h40000000, 32'h3F000000, 32'h40800000, 1'b0);
      add(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0);
      add(32'h00FFFFFF, 32'h40000000, 32'h00800000, 1'b0);
      add(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1);
      add(32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1);
      add(32'h00000001, 32'h3F800000, 32'h00000001, 1'b0);
      add(32'h3F800001, 32'h3F800000, 32'h3F800001, 1'b0);

      // Reset with in_valid high must still leave the output stage cleared.
      rst = 1'b1; in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h40400000;
      @(negedge clk);
      @(negedge clk);
      chk("reset out_valid", {66'd0, out_valid}, 67'd0);
      chk("reset y", {35'd0, y}, 67'd0);
      chk("reset ovf", {66'd0, ovf}, 67'd0);
      chk("reset s2a", {62'd0, s2a}, 67'd0);
      chk("reset mm", mm, 67'd0);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("idle out_valid", {66'd0, out_valid}, 67'd0);

      foreach (vecs[i]) begin
         drive(i, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ovf);
         @(negedge clk);
         check_out();
      end

      in_valid = 1'b0;
      @(negedge clk);
      chk("hold out_valid", {66'd0, out_valid}, 67'd0);
      chk("hold y", {35'd0, y}, {35'd0, vecs[vecs.size() - 1].y});
      for (int k = 0; k < 8 && sb.size() != 0; k++) begin
         @(negedge clk);
         check_out();
      end
      chk("scoreboard drained", 67'(sb.size()), 67'd0);

      // A result launched alongside rst is dropped; the unit recovers on the next operation.
      drive(100, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
      @(negedge clk);
      check_out();
      x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      chk("drop out_valid", {66'd0, out_valid}, 67'd0);
      chk("drop y", {35'd0, y}, 67'd0);
      chk("drop ovf", {66'd0, ovf}, 67'd0);
      rst = 1'b0;
      drive(101, 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
      @(negedge clk);
      check_out();
      in_valid = 1'b0;
      @(negedge clk);
      check_out();
      chk("final drained", 67'(sb.size()), 67'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
